// File: rtl/sram_pkg.sv
// sram_pkg: shared width defaults, FSM states and request entry layout for sram_req_queue.
package sram_pkg;
  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;
  typedef struct packed {
    logic              wr;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } op_t;
endpackage

// File: rtl/sram_req_queue_if.sv
// sram_req_queue_if: host request/response and controller strobe bundle for sram_req_queue.
interface sram_req_queue_if #(parameter int AW = 4, parameter int DW = 8);
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_rd, mem_wr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          rsp_valid, busy, err;
  logic [DW-1:0] rsp_rdata;
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, mem_rd, mem_wr, mem_addr, mem_wdata, rsp_valid, rsp_rdata, busy, err
  );
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, mem_rd, mem_wr, mem_addr, mem_wdata, rsp_valid, rsp_rdata, busy, err
  );
endinterface

// File: rtl/sram_req_fifo.sv
// sram_req_fifo: synchronous FIFO, power-of-two DEPTH, registered count with push/pop/full/empty.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din;
  assign dout  = mem_q[rd_ptr_q];
  assign full  = count_q == (PW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/sram_req_queue.sv
// sram_req_queue: FIFO-buffered request issuer for sram_controller, one op outstanding, in-order read responses.
// Define SRAM_REQ_TIMEOUT_EN to abort waits after TIMEOUT cycles and raise the sticky err flag.
module sram_req_queue import sram_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef SRAM_REQ_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input logic             clk,
  input logic             reset_n,
  sram_req_queue_if.slave bus
);
  localparam int W = 1 + AW + DW;
  logic [W-1:0]          head;
  logic                  push, pop, fifo_full, fifo_empty, waiting;
  logic [$clog2(DEPTH):0] fifo_count;
  state_t                state_q, state_d;
  logic                  op_wr_q, op_wr_d, rsp_q, rsp_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef SRAM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, expired;
`endif
  assign push    = bus.req_valid & bus.req_ready;
  assign waiting = state_q inside {WAIT_LO, WAIT_HI};
  sram_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .din({bus.req_wr, bus.req_addr, bus.req_wdata}), .dout(head),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  // Head fields are captured on entry to ISSUE so the strobe cycle drives registered addr/data.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (!fifo_empty && bus.mem_ready) begin
        state_d = ISSUE;
        {op_wr_d, addr_d, wdata_d} = head;
      end
      ISSUE:   begin
        pop     = 1'b1;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (!bus.mem_ready) state_d = WAIT_HI;
      WAIT_HI: if (bus.mem_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
`ifdef SRAM_REQ_TIMEOUT_EN
    cnt_d   = state_q == ISSUE ? '0 : waiting ? cnt_q + TW'(1) : cnt_q;
    expired = waiting && cnt_d == TW'(TIMEOUT);
    err_d   = err_q | expired;
    if (expired) state_d = IDLE;
`endif
    rsp_d   = state_d == DONE && !op_wr_q;
    rdata_d = rsp_d ? bus.mem_rdata : rdata_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
`ifdef SRAM_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.req_ready = ~fifo_full;
  assign bus.mem_rd    = state_q == ISSUE && !op_wr_q;
  assign bus.mem_wr    = state_q == ISSUE && op_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = fifo_count != '0 || state_q != IDLE;
endmodule

// File: tb/tb_sram_req_queue.sv
// tb_sram_req_queue: directed bench for sram_req_queue with a behavioural sram_controller model.
module tb_sram_req_queue;
  import sram_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  sram_req_queue_if #(.AW(4), .DW(8)) bus ();
  sram_req_queue #(.DEPTH(4), .AW(4), .DW(8)
`ifdef SRAM_REQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // Controller model: samples a strobe while ready, then busy for a few cycles.
  logic        ready_m = 1'b1;
  logic        stall = 1'b0;
  logic        hang = 1'b0;
  logic [7:0]  smem [16];
  logic [15:0] wrote = '0;
  logic [7:0]  rdata_m = '0;
  int          lat = 0;
  assign bus.mem_ready = ready_m & ~stall;
  assign bus.mem_rdata = rdata_m;
  always @(posedge clk) begin
    if ((bus.mem_rd || bus.mem_wr) && bus.mem_ready) begin
      if (bus.mem_wr) begin
        smem[bus.mem_addr]  <= bus.mem_wdata;
        wrote[bus.mem_addr] <= 1'b1;
      end else rdata_m <= wrote[bus.mem_addr] ? smem[bus.mem_addr] : 8'hA0 + 8'(bus.mem_addr);
      ready_m <= 1'b0;
      lat     <= 2;
    end else if (!ready_m && lat > 0) lat <= lat - 1;
    else if (!ready_m && !hang) ready_m <= 1'b1;
  end
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrs = 0;
  op_t  slog [$];
  int   scyc [$];
  logic srdy [$];
  logic [7:0] rlog [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.mem_rd || bus.mem_wr) begin
      slog.push_back({bus.mem_wr, bus.mem_addr, bus.mem_wdata});
      scyc.push_back(cyc);
      srdy.push_back(bus.req_ready);
      check("strobe_excl", 32'(bus.mem_rd & bus.mem_wr), 0);
    end
    if (bus.rsp_valid) rlog.push_back(bus.rsp_rdata);
  end
  function automatic op_t sop(input int i);
    return (i < slog.size()) ? slog[i] : '1;
  endfunction
  function automatic logic [7:0] rsp(input int i);
    return (i < rlog.size()) ? rlog[i] : 8'hxx;
  endfunction
  task automatic clear_logs();
    slog.delete();
    scyc.delete();
    srdy.delete();
    rlog.delete();
  endtask
  task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", 32'(bus.req_ready), 1);
    acc = cyc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p, p5, n;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 0);
    check("rst_rsp", 32'(bus.rsp_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    reset_n = 1'b1;
    // Single write
    clear_logs();
    push(1'b1, 4'h4, 8'h5A, p);
    wait_idle("w1_idle");
    check("w1_count", slog.size(), 1);
    check("w1_op", 32'(sop(0)), 32'({1'b1, 4'h4, 8'h5A}));
    check("w1_latency", scyc.size() > 0 ? scyc[0] - p : -1, 2);
    check("w1_norsp", rlog.size(), 0);
    // Write then read back, plus a read of an unwritten address
    clear_logs();
    push(1'b1, 4'h4, 8'h5A, p);
    push(1'b0, 4'h4, 8'h00, p);
    push(1'b0, 4'h9, 8'h00, p);
    wait_idle("wr_idle");
    check("wr_count", slog.size(), 3);
    check("wr_op0", 32'(sop(0)), 32'({1'b1, 4'h4, 8'h5A}));
    check("wr_op1", 32'({sop(1).wr, sop(1).addr}), 32'({1'b0, 4'h4}));
    check("wr_op2", 32'({sop(2).wr, sop(2).addr}), 32'({1'b0, 4'h9}));
    check("wr_rsp_count", rlog.size(), 2);
    check("wr_rsp0", 32'(rsp(0)), 32'h5A);
    check("wr_rsp1", 32'(rsp(1)), 32'hA9);
    // Fill with controller stalled, then push into a full FIFO as it drains
    clear_logs();
    stall = 1'b1;
    push(1'b1, 4'h1, 8'h11, p);
    push(1'b1, 4'h2, 8'h22, p);
    push(1'b0, 4'h1, 8'h00, p);
    push(1'b0, 4'h2, 8'h00, p);
    @(negedge clk);
    check("fill_ready", 32'(bus.req_ready), 0);
    check("fill_busy", 32'(bus.busy), 1);
    check("fill_noissue", slog.size(), 0);
    stall = 1'b0;
    push(1'b1, 4'h3, 8'h33, p5);
    check("full_issue_ready", 32'(srdy.size() > 0 ? srdy[0] : 1'b1), 0);
    check("full_accept_cycle", scyc.size() > 0 ? p5 - scyc[0] : -1, 1);
    @(negedge clk);
    check("full_again", 32'(bus.req_ready), 0);
    wait_idle("fill_idle");
    check("fill_count", slog.size(), 5);
    check("fill_op0", 32'(sop(0)), 32'({1'b1, 4'h1, 8'h11}));
    check("fill_op1", 32'(sop(1)), 32'({1'b1, 4'h2, 8'h22}));
    check("fill_op2", 32'({sop(2).wr, sop(2).addr}), 32'({1'b0, 4'h1}));
    check("fill_op3", 32'({sop(3).wr, sop(3).addr}), 32'({1'b0, 4'h2}));
    check("fill_op4", 32'(sop(4)), 32'({1'b1, 4'h3, 8'h33}));
    check("fill_rsp_count", rlog.size(), 2);
    check("fill_rsp0", 32'(rsp(0)), 32'h11);
    check("fill_rsp1", 32'(rsp(1)), 32'h22);
    check("fill_ready_end", 32'(bus.req_ready), 1);
    check("fill_err", 32'(bus.err), 0);
    // Reset while WAIT_HI with two entries queued
    clear_logs();
    push(1'b0, 4'h5, 8'h00, p);
    push(1'b1, 4'h6, 8'h66, p);
    push(1'b1, 4'h7, 8'h77, p);
    n = 0;
    while (slog.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_strobe", slog.size(), 1);
    while (scyc.size() > 0 && cyc < scyc[0] + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 1);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    check("mid_rst_rdata", 32'(bus.rsp_rdata), 0);
    clear_logs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_nostrobe", slog.size(), 0);
    check("post_rst_norsp", rlog.size(), 0);
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_ready", 32'(bus.req_ready), 1);
`ifdef SRAM_REQ_TIMEOUT_EN
    // Controller never completes the read: abort after 16 wait cycles, next op still issues
    clear_logs();
    hang = 1'b1;
    push(1'b0, 4'h8, 8'h00, p);
    push(1'b1, 4'h9, 8'h99, p);
    n = 0;
    while (!bus.err && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("to_err", 32'(bus.err), 1);
    check("to_cycles", scyc.size() > 0 ? cyc - scyc[0] : -1, 17);
    check("to_held", slog.size(), 1);
    hang = 1'b0;
    wait_idle("to_idle");
    check("to_count", slog.size(), 2);
    check("to_next_op", 32'(sop(1)), 32'({1'b1, 4'h9, 8'h99}));
    check("to_norsp", rlog.size(), 0);
    check("to_sticky", 32'(bus.err), 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
